// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - multichannel I2S frame capture into the audio input RAM
//
// Purpose: on each accepted sample_en strobe, latch one multichannel frame
// into a shadow register and write it to the audio RAM one channel per cycle
// at address {chan, frame}, walking frame downwards through a FRAMES-deep
// history. A one-cycle frame_done pulse follows the last channel write.
// Optional feature: define AUDIO_CAPTURE_OVERRUN_EN to build the sticky
// overrun flag and an 8-bit saturating drop counter (drop_cnt, debug only).
//
// Ports:
//   ck          system clock
//   rst_n       asynchronous active-low reset
//   sample_en   one-cycle strobe, samples valid
//   samples     CHANNELS x IN_W two's complement samples, channel c at [c*IN_W +: IN_W]
//   chan_mask   per-channel capture enable, 0 writes zero
//   freeze      host owns the RAM, strobes in IDLE are ignored
//   clr_overrun clears the overrun flag and drop counter
//   we/waddr/wdata  RAM write port
//   frame       current frame index
//   frame_done  one-cycle pulse after the last channel write
//   busy        high while a frame is being written
//   overrun     sticky dropped-strobe flag
module audio_capture #(
  parameter int CHANNELS = 8,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int FRAMES   = 256,
  parameter int CHAN_W   = $clog2(CHANNELS),
  parameter int FRAME_W  = $clog2(FRAMES),
  parameter int AUDIO_W  = CHAN_W + FRAME_W
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     sample_en,
  input  logic [CHANNELS*IN_W-1:0] samples,
  input  logic [CHANNELS-1:0]      chan_mask,
  input  logic                     freeze,
  input  logic                     clr_overrun,
  output logic                     we,
  output logic [AUDIO_W-1:0]       waddr,
  output logic [OUT_W-1:0]         wdata,
  output logic [FRAME_W-1:0]       frame,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                   state, state_n;
  logic [CHAN_W-1:0]        chan, chan_n, chan_inc;
  logic [CHANNELS*IN_W-1:0] shadow, shadow_n;
  logic [CHANNELS-1:0]      mask_sh, mask_n;
  logic [FRAME_W-1:0]       frame_n, frame_dec;
  logic                     we_n, frame_done_n, drop;
  logic [AUDIO_W-1:0]       waddr_n;
  logic [OUT_W-1:0]         wdata_n;

  // Sign-extend into the wider of the two widths, then keep the top OUT_W
  // bits: this truncates when narrowing and sign-extends when widening.
  function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] s);
    logic signed [MAX_W-1:0] ext;
    ext = MAX_W'($signed(s));
    return ext[MAX_W-1 -: OUT_W];
  endfunction

  function automatic logic [OUT_W-1:0] word(input logic [CHANNELS*IN_W-1:0] d,
                                            input logic [CHANNELS-1:0] m,
                                            input logic [CHAN_W-1:0] c);
    return m[c] ? conv(d[int'(c)*IN_W +: IN_W]) : '0;
  endfunction

  assign chan_inc  = chan + CHAN_W'(1);
  assign frame_dec = frame - FRAME_W'(1);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chan       <= '0;
      shadow     <= '0;
      mask_sh    <= '0;
      frame      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      chan       <= chan_n;
      shadow     <= shadow_n;
      mask_sh    <= mask_n;
      frame      <= frame_n;
      we         <= we_n;
      waddr      <= waddr_n;
      wdata      <= wdata_n;
      frame_done <= frame_done_n;
      busy       <= (state_n != IDLE);
    end
  end

  // Outputs are computed one cycle ahead so the RAM port is fully registered;
  // the first word of a frame therefore comes straight from the inputs.
  always_comb begin
    state_n      = state;
    chan_n       = chan;
    shadow_n     = shadow;
    mask_n       = mask_sh;
    frame_n      = frame;
    we_n         = 1'b0;
    waddr_n      = waddr;
    wdata_n      = wdata;
    frame_done_n = 1'b0;
    drop         = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en && !freeze) begin
          shadow_n = samples;
          mask_n   = chan_mask;
          frame_n  = frame_dec;
          chan_n   = '0;
          we_n     = 1'b1;
          waddr_n  = {CHAN_W'(0), frame_dec};
          wdata_n  = word(samples, chan_mask, CHAN_W'(0));
          state_n  = WRITE;
        end
      end
      WRITE: begin
        drop = sample_en;
        if (chan == CHAN_W'(CHANNELS - 1)) begin
          frame_done_n = 1'b1;
          state_n      = DONE;
        end else begin
          chan_n  = chan_inc;
          we_n    = 1'b1;
          waddr_n = {chan_inc, frame};
          wdata_n = word(shadow, mask_sh, chan_inc);
        end
      end
      DONE: begin
        drop    = sample_en;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef AUDIO_CAPTURE_OVERRUN_EN
  logic [7:0] drop_cnt;

  // A drop in the same cycle as clr_overrun leaves the flag set.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
      if (clr_overrun)
        drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = clr_overrun ^ drop;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_capture.sv
// tb/tb_audio_capture.sv - self-checking bench for audio_capture
module tb_audio_capture;

  localparam int CH = 8;
  localparam int IW = 16;
  localparam int FR = 256;

`ifdef AUDIO_CAPTURE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic          rst_n, sample_en, freeze, clr_overrun;
  logic [127:0]  samples;
  logic [7:0]    chan_mask;
  logic          we, frame_done, busy, overrun;
  logic [10:0]   waddr;
  logic [15:0]   wdata;
  logic [7:0]    frame;

  audio_capture dut (
    .ck(ck), .rst_n(rst_n), .sample_en(sample_en), .samples(samples),
    .chan_mask(chan_mask), .freeze(freeze), .clr_overrun(clr_overrun),
    .we(we), .waddr(waddr), .wdata(wdata), .frame(frame),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  // width-conversion instances: 24->16 truncation and 16->24 sign extension
  logic        se_x;
  logic [47:0] s24;
  logic [31:0] s16;
  logic        we_a, fd_a, busy_a, ovr_a, we_b, fd_b, busy_b, ovr_b;
  logic [2:0]  waddr_a, waddr_b;
  logic [15:0] wdata_a;
  logic [23:0] wdata_b;
  logic [1:0]  frame_a, frame_b;

  audio_capture #(.CHANNELS(2), .IN_W(24), .OUT_W(16), .FRAMES(4)) u_trunc (
    .ck(ck), .rst_n(rst_n), .sample_en(se_x), .samples(s24),
    .chan_mask(2'b11), .freeze(1'b0), .clr_overrun(1'b0),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .frame(frame_a),
    .frame_done(fd_a), .busy(busy_a), .overrun(ovr_a)
  );

  audio_capture #(.CHANNELS(2), .IN_W(16), .OUT_W(24), .FRAMES(4)) u_sext (
    .ck(ck), .rst_n(rst_n), .sample_en(se_x), .samples(s16),
    .chan_mask(2'b11), .freeze(1'b0), .clr_overrun(1'b0),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .frame(frame_b),
    .frame_done(fd_b), .busy(busy_b), .overrun(ovr_b)
  );

  int checks = 0;
  int failures = 0;
  int exp_frame = 0;
  bit exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One accepted frame starting now; optional second strobe drop_at cycles
  // after the accepted one. Inputs are scrambled during the write so that
  // only the latched frame can produce the expected data.
  task automatic run_frame(input logic [127:0] s, input logic [7:0] m,
                           input int drop_at, input bit clr_at_drop);
    logic [15:0] e;
    samples   = s;
    chan_mask = m;
    sample_en = 1'b1;
    exp_frame = (exp_frame + FR - 1) % FR;
    @(negedge ck);
    chk("frame_t1", 64'(frame), 64'(exp_frame));
    for (int c = 0; c < CH; c++) begin
      e = m[c] ? s[c*IW +: IW] : 16'h0000;
      chk("we", 64'(we), 64'd1);
      chk("waddr", 64'(waddr), 64'(c * FR + exp_frame));
      chk("wdata", 64'(wdata), 64'(e));
      chk("busy_w", 64'(busy), 64'd1);
      samples     = rnd128();
      chan_mask   = 8'($urandom());
      sample_en   = (c + 1 == drop_at);
      clr_overrun = (c + 1 == drop_at) && clr_at_drop;
      if (c + 1 == drop_at && OVR_EN) exp_ovr = 1'b1;
      @(negedge ck);
    end
    sample_en   = 1'b0;
    clr_overrun = 1'b0;
    chk("frame_done", 64'(frame_done), 64'd1);
    chk("we_done", 64'(we), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    @(negedge ck);
    chk("frame_done_end", 64'(frame_done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("overrun", 64'(overrun), 64'(exp_ovr));
  endtask

  task automatic clear_overrun();
    clr_overrun = 1'b1;
    @(negedge ck);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    chk("overrun_clr", 64'(overrun), 64'd0);
  endtask

  initial begin
    logic [127:0] s;
    logic [23:0]  r24;
    logic [15:0]  r16;
    int           bad;
    rst_n = 1'b0; sample_en = 1'b0; freeze = 1'b0; clr_overrun = 1'b0;
    samples = '0; chan_mask = '0; se_x = 1'b0; s24 = '0; s16 = '0;
    repeat (3) @(negedge ck);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_frame", 64'(frame), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    @(negedge ck);
    chk("idle_we", 64'(we), 64'd0);

    // directed ramp, full mask then mask 0xA5
    for (int c = 0; c < CH; c++) s[c*IW +: IW] = 16'(16'h1000 + c);
    run_frame(s, 8'hFF, 0, 1'b0);
    chk("frame_first", 64'(frame), 64'hFF);
    run_frame(s, 8'hA5, 0, 1'b0);

    // random frames back to back at the minimum spacing
    for (int i = 0; i < 4; i++) run_frame(rnd128(), 8'($urandom()), 0, 1'b0);

    // dropped strobe at t+4, then a drop coinciding with clr_overrun
    run_frame(rnd128(), 8'($urandom()), 4, 1'b0);
    clear_overrun();
    run_frame(rnd128(), 8'($urandom()), 5, 1'b1);
    clear_overrun();

    // width conversion on the two small instances
    r24 = 24'($urandom());
    r16 = 16'($urandom());
    s24 = {r24, 24'h801234};
    s16 = {r16, 16'h8001};
    se_x = 1'b1;
    @(negedge ck);
    se_x = 1'b0;
    chk("trunc_waddr0", 64'(waddr_a), 64'd3);
    chk("trunc_data0", 64'(wdata_a), 64'h8012);
    chk("sext_data0", 64'(wdata_b), 64'hFF8001);
    @(negedge ck);
    chk("trunc_waddr1", 64'(waddr_a), 64'd7);
    chk("trunc_data1", 64'(wdata_a), 64'(r24 / 256));
    chk("sext_data1", 64'(wdata_b), 64'((r16 >= 16'h8000) ? 32'(r16) + 32'hFF0000 : 32'(r16)));
    repeat (3) @(negedge ck);

    // wrap: restart from reset, 257 strobes spaced 12 cycles
    rst_n = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    exp_frame = 0;
    exp_ovr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      run_frame(rnd128(), 8'($urandom()), 0, 1'b0);
      repeat (2) @(negedge ck);
    end
    chk("frame_wrap", 64'(frame), 64'hFF);

    // freeze: strobes ignored
    freeze = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      samples = rnd128();
      sample_en = 1'b1;
      @(negedge ck);
      sample_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (we !== 1'b0 || busy !== 1'b0 || frame !== 8'(exp_frame)) bad++;
        @(negedge ck);
      end
    end
    chk("freeze_no_write", 64'(bad), 64'd0);
    chk("freeze_frame", 64'(frame), 64'(exp_frame));
    chk("freeze_overrun", 64'(overrun), 64'(exp_ovr));
    freeze = 1'b0;

    // asynchronous reset in the middle of a frame
    samples = rnd128();
    chan_mask = 8'hFF;
    sample_en = 1'b1;
    @(negedge ck);
    sample_en = 1'b0;
    chk("pre_rst_we", 64'(we), 64'd1);
    repeat (3) @(negedge ck);
    rst_n = 1'b0;
    #1;
    chk("async_we", 64'(we), 64'd0);
    chk("async_frame", 64'(frame), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_waddr", 64'(waddr), 64'd0);
    @(negedge ck);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (we !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge ck);
    end
    chk("no_done_after_rst", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
